enemy_spawner_ctrl: RTL and testbench

- Parametrised successor to the single-kind enemy mover. Owns a fixed table of NSLOTS obstacle slots.
- On each frame tick it scrolls every live slot left by a run-time speed and retires slots that leave the screen.
- It spawns new obstacles of four kinds with an LFSR-randomised minimum gap.
- Sits between the game-state FSM (run/clear/speed) and the renderer/collision logic, which read the packed slot table.

---
 rtl/enemy_pkg.sv | 47 ++++
 rtl/enemy_lfsr16.sv | 34 +++
 rtl/enemy_spawner_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_enemy_spawner_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared definitions for the obstacle spawner: FSM states, obstacle kinds,
// per-kind geometry and slot-table layout.
package enemy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] KIND_CACTUS_S = 2'd0;
    localparam logic [1:0] KIND_CACTUS_L = 2'd1;
    localparam logic [1:0] KIND_BIRD_LO  = 2'd2;
    localparam logic [1:0] KIND_BIRD_HI  = 2'd3;

    localparam int CACTUS_S_W = 16;
    localparam int CACTUS_S_H = 32;
    localparam int CACTUS_L_W = 24;
    localparam int CACTUS_L_H = 48;
    localparam int BIRD_W     = 32;
    localparam int BIRD_H     = 20;

    // Slot header: two reserved zero bits on top, then valid(1) and kind(2).
    localparam int         SLOT_HDR_W = 5;
    localparam logic [1:0] SLOT_PAD   = 2'b00;

    function automatic int slot_width(input int x_w, input int y_w, input int sz_w);
        return SLOT_HDR_W + x_w + y_w + 2 * sz_w;
    endfunction

    function automatic int kind_w(input logic [1:0] kind);
        case (kind)
            KIND_CACTUS_S: return CACTUS_S_W;
            KIND_CACTUS_L: return CACTUS_L_W;
            default:       return BIRD_W;
        endcase
    endfunction

    function automatic int kind_h(input logic [1:0] kind);
        case (kind)
            KIND_CACTUS_S: return CACTUS_S_H;
            KIND_CACTUS_L: return CACTUS_L_H;
            default:       return BIRD_H;
        endcase
    endfunction

endpackage

// File: rtl/enemy_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11), reloaded with SEED on reset.
module enemy_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk3,
    input  logic        rst_n,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_nxt_s;

    // One Galois step; the zero guard keeps the register out of the lock-up state
    always_comb begin
        lfsr_nxt_s = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_nxt_s = lfsr_nxt_s ^ 16'hB400;
        end else begin
        end
        if (lfsr_nxt_s == 16'h0000) begin
            lfsr_nxt_s = SEED;
        end else begin
        end
    end

    // LFSR state register
    always_ff @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_nxt_s;
        end
    end

endmodule

// File: rtl/enemy_spawner_ctrl.sv
// Obstacle slot table: per-frame scroll and retire of live slots plus
// LFSR-paced spawning of four obstacle kinds into the lowest free slot.
module enemy_spawner_ctrl
    import enemy_pkg::*;
#(
    parameter int          NSLOTS    = 6,
    parameter int          X_W       = 10,
    parameter int          Y_W       = 9,
    parameter int          SZ_W      = 7,
    parameter int          SPEED_W   = 4,
    parameter int          SCREEN_W  = 640,
    parameter int          GROUND_Y  = 400,
    parameter int          BIRD_LO_Y = 360,
    parameter int          BIRD_HI_Y = 300,
    parameter int          MIN_GAP   = 40,
    parameter logic [7:0]  GAP_MASK  = 8'h3F,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         SLOT_W    = slot_width(X_W, Y_W, SZ_W)
) (
    input  logic                     clk3,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    input  logic                     run,
    input  logic                     clear,
    input  logic [SPEED_W-1:0]       speed,
    output logic [NSLOTS*SLOT_W-1:0] slots_o,
    output logic [3:0]               active_count,
    output logic                     spawn_pulse
);

    localparam int CD_W = $clog2(MIN_GAP + 256) + 1;

    state_t            state_r, state_nxt_s;
    logic [15:0]       lfsr_s;
    logic [5:0]        lfsr_unused_s;
    logic [CD_W-1:0]   cooldown_r, cooldown_nxt_s;
    logic              tick_s, flush_s, spawn_s, free_found_s;
    logic [3:0]        free_idx_s, count_nxt_s;
    logic [NSLOTS-1:0] valid_vec_s, valid_nxt_vec_s;
    logic [X_W-1:0]    speed_x_s;
    logic [1:0]        spawn_kind_s;
    logic [Y_W-1:0]    spawn_y_s;
    logic [SZ_W-1:0]   spawn_w_s, spawn_h_s;

    enemy_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk3  (clk3),
        .rst_n (rst_n),
        .lfsr  (lfsr_s)
    );

    assign lfsr_unused_s = lfsr_s[7:2];
    assign speed_x_s     = X_W'(speed);
    // clear wins over run and frame_tick
    assign flush_s       = clear || (state_r == ST_FLUSH);
    assign tick_s        = (state_r == ST_RUN) && run && frame_tick && !clear;
    assign spawn_s       = tick_s && (cooldown_r == '0) && free_found_s;

    // FSM state register
    always_ff @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = run ? ST_RUN : ST_IDLE;
                ST_RUN:   state_nxt_s = run ? ST_RUN : ST_IDLE;
                ST_FLUSH: state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Spawn cooldown: counts frames down, then holds at zero until a slot is free
    always_comb begin
        cooldown_nxt_s = cooldown_r;
        if (flush_s) begin
            cooldown_nxt_s = CD_W'(MIN_GAP);
        end else if (tick_s) begin
            if (cooldown_r != '0) begin
                cooldown_nxt_s = cooldown_r - CD_W'(1);
            end else if (free_found_s) begin
                cooldown_nxt_s = CD_W'(MIN_GAP) + CD_W'(lfsr_s[15:8] & GAP_MASK);
            end else begin
                cooldown_nxt_s = cooldown_r;
            end
        end else begin
            cooldown_nxt_s = cooldown_r;
        end
    end

    // Cooldown register
    always_ff @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) begin
            cooldown_r <= CD_W'(MIN_GAP);
        end else begin
            cooldown_r <= cooldown_nxt_s;
        end
    end

    // Kind and fixed geometry of the obstacle that would be spawned this cycle
    always_comb begin
        spawn_kind_s = lfsr_s[1:0];
        spawn_w_s    = SZ_W'(kind_w(spawn_kind_s));
        spawn_h_s    = SZ_W'(kind_h(spawn_kind_s));
        case (spawn_kind_s)
            KIND_BIRD_LO: spawn_y_s = Y_W'(BIRD_LO_Y);
            KIND_BIRD_HI: spawn_y_s = Y_W'(BIRD_HI_Y);
            default:      spawn_y_s = Y_W'(GROUND_Y);
        endcase
    end

    // Lowest-index slot that is free before this tick's update
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = 4'd0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (!valid_vec_s[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = 4'(i);
            end else begin
            end
        end
    end

    for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
        logic            valid_r, valid_nxt_s, hit_s;
        logic [1:0]      kind_r, kind_nxt_s;
        logic [X_W-1:0]  x_r, x_nxt_s;
        logic [Y_W-1:0]  y_r, y_nxt_s;
        logic [SZ_W-1:0] w_r, w_nxt_s, h_r, h_nxt_s;

        assign hit_s = spawn_s && (free_idx_s == 4'(g));

        // Next slot contents: flush, spawn write (unmoved), scroll/retire, or hold
        always_comb begin
            valid_nxt_s = valid_r;
            kind_nxt_s  = kind_r;
            x_nxt_s     = x_r;
            y_nxt_s     = y_r;
            w_nxt_s     = w_r;
            h_nxt_s     = h_r;
            if (flush_s) begin
                valid_nxt_s = 1'b0;
            end else if (hit_s) begin
                valid_nxt_s = 1'b1;
                kind_nxt_s  = spawn_kind_s;
                x_nxt_s     = X_W'(SCREEN_W);
                y_nxt_s     = spawn_y_s;
                w_nxt_s     = spawn_w_s;
                h_nxt_s     = spawn_h_s;
            end else if (tick_s && valid_r && (speed != '0)) begin
                if (x_r <= speed_x_s) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    x_nxt_s = x_r - speed_x_s;
                end
            end else begin
                valid_nxt_s = valid_r;
            end
        end

        // Slot storage
        always_ff @(posedge clk3 or negedge rst_n) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                kind_r  <= 2'd0;
                x_r     <= '0;
                y_r     <= '0;
                w_r     <= '0;
                h_r     <= '0;
            end else begin
                valid_r <= valid_nxt_s;
                kind_r  <= kind_nxt_s;
                x_r     <= x_nxt_s;
                y_r     <= y_nxt_s;
                w_r     <= w_nxt_s;
                h_r     <= h_nxt_s;
            end
        end

        assign valid_vec_s[g]     = valid_r;
        assign valid_nxt_vec_s[g] = valid_nxt_s;
        assign slots_o[g*SLOT_W +: SLOT_W] = {SLOT_PAD, valid_r, kind_r, x_r, y_r, w_r, h_r};
    end

    // Population count of the table as it will be after this cycle
    always_comb begin
        count_nxt_s = 4'd0;
        for (int i = 0; i < NSLOTS; i++) begin
            count_nxt_s = count_nxt_s + {3'b000, valid_nxt_vec_s[i]};
        end
    end

    // Registered status outputs
    always_ff @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) begin
            active_count <= 4'd0;
            spawn_pulse  <= 1'b0;
        end else begin
            active_count <= count_nxt_s;
            spawn_pulse  <= spawn_s;
        end
    end

endmodule

// File: tb/tb_enemy_spawner_ctrl.sv
// Directed bench for enemy_spawner_ctrl: expected spawns are queued at stimulus
// time and popped by a monitor whenever spawn_pulse is seen.
`timescale 1ns/1ps
module tb_enemy_spawner_ctrl;

    localparam int NSLOTS = 6;
    localparam int SW     = 38;

    logic clk3 = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic run = 1'b0;
    logic clear = 1'b0;
    logic [3:0] speed = 4'd0;
    logic [NSLOTS*SW-1:0] slots_o;
    logic [3:0] active_count;
    logic spawn_pulse;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] tb_lfsr;

    typedef struct {
        int         idx;
        logic [1:0] kind;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   kinds_seen[$];

    enemy_spawner_ctrl #(
        .NSLOTS(6), .X_W(10), .Y_W(9), .SZ_W(7), .SPEED_W(4), .SCREEN_W(640),
        .GROUND_Y(400), .BIRD_LO_Y(360), .BIRD_HI_Y(300), .MIN_GAP(2),
        .GAP_MASK(8'h00), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk3(clk3), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .clear(clear),
        .speed(speed), .slots_o(slots_o), .active_count(active_count), .spawn_pulse(spawn_pulse)
    );

    always #5 clk3 = ~clk3;

    // Reference LFSR: x^16+x^14+x^13+x^11 Galois form, right-shifting
    always @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) tb_lfsr <= 16'hACE1;
        else if (tb_lfsr[0]) tb_lfsr <= {1'b0, tb_lfsr[15:1]} ^ 16'hB400;
        else tb_lfsr <= {1'b0, tb_lfsr[15:1]};
    end

    function automatic logic [SW-1:0] slot(input int i);
        return slots_o[i*SW +: SW];
    endfunction
    function automatic int f_valid(input int i); logic [SW-1:0] s; s = slot(i); return int'(s[35]);    endfunction
    function automatic int f_kind(input int i);  logic [SW-1:0] s; s = slot(i); return int'(s[34:33]); endfunction
    function automatic int f_x(input int i);     logic [SW-1:0] s; s = slot(i); return int'(s[32:23]); endfunction
    function automatic int f_y(input int i);     logic [SW-1:0] s; s = slot(i); return int'(s[22:14]); endfunction
    function automatic int f_w(input int i);     logic [SW-1:0] s; s = slot(i); return int'(s[13:7]);  endfunction
    function automatic int f_h(input int i);     logic [SW-1:0] s; s = slot(i); return int'(s[6:0]);   endfunction

    function automatic int exp_y(input int k);
        case (k) 0, 1: return 400; 2: return 360; default: return 300; endcase
    endfunction
    function automatic int exp_w(input int k);
        case (k) 0: return 16; 1: return 24; default: return 32; endcase
    endfunction
    function automatic int exp_h(input int k);
        case (k) 0: return 32; 1: return 48; default: return 20; endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every spawn_pulse must match the oldest queued expectation
    always @(negedge clk3) begin
        if (rst_n && spawn_pulse) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_spawn", int'(spawn_pulse), 0);
            end else begin
                mon_e = exp_q.pop_front();
                kinds_seen.push_back(f_kind(mon_e.idx));
                chk("spawn_valid", f_valid(mon_e.idx), 1);
                chk("spawn_kind",  f_kind(mon_e.idx), int'(mon_e.kind));
                chk("spawn_x",     f_x(mon_e.idx), 640);
                chk("spawn_y",     f_y(mon_e.idx), exp_y(int'(mon_e.kind)));
                chk("spawn_w",     f_w(mon_e.idx), exp_w(int'(mon_e.kind)));
                chk("spawn_h",     f_h(mon_e.idx), exp_h(int'(mon_e.kind)));
            end
        end
    end

    // One frame: pulse frame_tick for a cycle, then one idle cycle; called at a negedge
    task automatic tick(input bit exp_spawn, input int idx);
        exp_t e;
        frame_tick = 1'b1;
        if (exp_spawn) begin
            e.idx  = idx;
            e.kind = tb_lfsr[1:0];
            exp_q.push_back(e);
        end
        @(negedge clk3);
        frame_tick = 1'b0;
        @(negedge clk3);
    endtask

    // Identical cycle sequence after every reset release
    task automatic startup();
        chk("rst_slots_zero", int'(slots_o == '0), 1);
        chk("rst_count", int'(active_count), 0);
        chk("rst_pulse", int'(spawn_pulse), 0);
        for (int i = 0; i < 10; i++) tick(1'b0, 0);
        chk("idle_slots_zero", int'(slots_o == '0), 1);
        chk("idle_count", int'(active_count), 0);
        run = 1'b1;
        speed = 4'd4;
        @(negedge clk3);
        tick(1'b0, 0); chk("t1_count", int'(active_count), 0);
        tick(1'b0, 0); chk("t2_count", int'(active_count), 0);
        tick(1'b1, 0); chk("t3_count", int'(active_count), 1); chk("t3_x0", f_x(0), 640);
        tick(1'b0, 0); chk("t4_x0", f_x(0), 636);
        tick(1'b0, 0); chk("t5_x0", f_x(0), 632); chk("t5_count", int'(active_count), 1);
        tick(1'b1, 1); chk("t6_count", int'(active_count), 2);
        chk("t6_x0", f_x(0), 628); chk("t6_x1", f_x(1), 640);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind0, kind1, base;
        kind0 = -1;
        kind1 = -1;
        repeat (3) @(negedge clk3);
        rst_n = 1'b1;
        startup();
        chk("run1_spawns", kinds_seen.size(), 2);
        if (kinds_seen.size() >= 2) begin
            kind0 = kinds_seen[0];
            kind1 = kinds_seen[1];
        end
        tick(1'b0, 0); chk("t7_x0", f_x(0), 624); chk("t7_x1", f_x(1), 636);

        // clear together with frame_tick: flush wins, no spawn, cooldown reloaded
        clear = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk3);
        clear = 1'b0;
        frame_tick = 1'b0;
        chk("clr_count", int'(active_count), 0);
        chk("clr_valid0", f_valid(0), 0);
        chk("clr_valid1", f_valid(1), 0);
        chk("clr_pulse", int'(spawn_pulse), 0);
        repeat (3) @(negedge clk3);

        // Frozen scroll: table fills, then spawning stalls
        speed = 4'd0;
        for (int t = 1; t <= 18; t++) tick(t % 3 == 0, t / 3 - 1);
        chk("fill_count", int'(active_count), 6);
        for (int t = 0; t < 5; t++) begin
            tick(1'b0, 0);
            chk("full_count", int'(active_count), 6);
        end
        chk("frozen_x5", f_x(5), 640);

        speed = 4'd15;
        for (int t = 0; t < 42; t++) tick(1'b0, 0);
        chk("scroll_x0", f_x(0), 10);
        chk("scroll_x5", f_x(5), 10);
        chk("scroll_count", int'(active_count), 6);
        speed = 4'd7;
        tick(1'b0, 0);
        chk("pre_retire_x0", f_x(0), 3);
        speed = 4'd4;
        tick(1'b0, 0);
        chk("retire_count", int'(active_count), 0);
        chk("retire_valid0", f_valid(0), 0);
        chk("retire_no_wrap", int'(f_x(0) == 1023), 0);
        tick(1'b1, 0);
        chk("respawn_count", int'(active_count), 1);
        chk("respawn_x0", f_x(0), 640);
        chk("respawn_valid1", f_valid(1), 0);

        // Asynchronous reset between clock edges
        @(posedge clk3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_slots_zero", int'(slots_o == '0), 1);
        chk("arst_count", int'(active_count), 0);
        chk("arst_pulse", int'(spawn_pulse), 0);
        run = 1'b0;
        speed = 4'd0;
        repeat (3) @(negedge clk3);
        rst_n = 1'b1;
        base = kinds_seen.size();
        startup();
        chk("run2_spawns", kinds_seen.size() - base, 2);
        if (kinds_seen.size() >= base + 2) begin
            chk("restart_kind0", kinds_seen[base], kind0);
            chk("restart_kind1", kinds_seen[base + 1], kind1);
        end
        repeat (2) @(negedge clk3);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
